// File: rtl/sim_exit_ctrl_pkg.sv
// sim_exit_ctrl_pkg
// Shared definitions for the simulation exit controller: register word
// offsets (decoded from addr[4:2]), the exit state enum, the default
// watchdog failure code and a byte-enable merge helper.
package sim_exit_ctrl_pkg;

  localparam logic [2:0] REG_EXIT_VALUE = 3'd0;  // 0x00
  localparam logic [2:0] REG_EXIT_VALID = 3'd1;  // 0x04
  localparam logic [2:0] REG_CYCLE_LO   = 3'd2;  // 0x08
  localparam logic [2:0] REG_CYCLE_HI   = 3'd3;  // 0x0C
  localparam logic [2:0] REG_WDT_LIMIT  = 3'd4;  // 0x10
  localparam logic [2:0] REG_WDT_KICK   = 3'd5;  // 0x14
  localparam logic [2:0] REG_STATUS     = 3'd6;  // 0x18

  localparam logic [31:0] WDT_EXIT_CODE_DEFAULT = 32'hDEAD_0001;

  typedef enum logic {
    RUN    = 1'b0,
    EXITED = 1'b1
  } exit_state_e;

  // Merge write data into an existing word, byte lane by byte lane.
  function automatic logic [31:0] apply_be(input logic [31:0] old_val,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sim_exit_ctrl_wdt.sv
// sim_exit_ctrl_wdt
// Watchdog counter. Counts while enabled (not frozen, limit non-zero),
// saturates at limit-1 and raises a single-cycle expiry indication when the
// count sits at limit-1 and no clear arrives in the same cycle.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   limit_i        current WDT_LIMIT value (0 disables)
//   clear_i        kick or limit write this cycle
//   freeze_i       controller has exited; counter holds
//   expire_o       expiry condition this cycle
module sim_exit_ctrl_wdt (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] limit_i,
  input  logic        clear_i,
  input  logic        freeze_i,
  output logic        expire_o
);

  logic [31:0] cnt_q, cnt_d;
  logic [31:0] limit_m1;
  logic        enable;
  logic        at_limit;

  assign limit_m1 = limit_i - 32'd1;
  assign enable   = !freeze_i && (limit_i != 32'd0);
  assign at_limit = (cnt_q == limit_m1);
  // A clear in the expiry cycle beats the expiry.
  assign expire_o = enable && at_limit && !clear_i;

  always_comb begin
    cnt_d = cnt_q;
    if (freeze_i) begin
      cnt_d = cnt_q;
    end else if (clear_i) begin
      cnt_d = 32'd0;
    end else if (enable && (cnt_q < limit_m1)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= 32'd0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sim_exit_ctrl.sv
// sim_exit_ctrl
// Memory-mapped simulation-control slave (OBI-style). Software writes an exit
// code then a valid strobe; the controller moves RUN -> EXITED and holds
// exit_valid_o high until reset. Includes a free-running 64-bit cycle counter
// (with a high-word shadow captured on CYCLE_LO reads) and a watchdog that
// forces an exit with WDT_EXIT_CODE.
// Handshake: gnt_o mirrors req_i (no wait states); every granted request,
// read or write, gets rvalid_o exactly one cycle later; rdata_o is registered
// and is zero whenever rvalid_o is low; writes take effect at the grant edge.
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   req_i, we_i, be_i, addr_i, wdata_i   request channel
//   gnt_o, rvalid_o, rdata_o   grant / response channel
//   exit_valid_o, exit_value_o exit flag (sticky) and exit code
module sim_exit_ctrl
  import sim_exit_ctrl_pkg::*;
#(
  parameter logic [31:0] WDT_EXIT_CODE   = WDT_EXIT_CODE_DEFAULT,
  parameter logic [31:0] WDT_RESET_LIMIT = 32'd0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        exit_valid_o,
  output logic [31:0] exit_value_o
);

  exit_state_e state_q, state_d;
  logic [31:0] exit_value_q, exit_value_d;
  logic [31:0] wdt_limit_q, wdt_limit_d;
  logic        wdt_expired_q, wdt_expired_d;
  logic [63:0] cycle_q;
  logic [31:0] shadow_q, shadow_d;
  logic        rvalid_q;
  logic [31:0] rdata_q, rdata_d;

  logic [2:0]  idx;
  logic        wr, rd, running, exited;
  logic        sw_exit, wdt_clear, wdt_expire;
  logic        unused_addr;

  assign idx         = addr_i[4:2];
  assign unused_addr = ^{addr_i[31:5], addr_i[1:0]};
  assign wr          = req_i && we_i;
  assign rd          = req_i && !we_i;
  assign running     = (state_q == RUN);
  assign exited      = (state_q == EXITED);

  assign sw_exit   = running && wr && (idx == REG_EXIT_VALID) && be_i[0] && wdata_i[0];
  assign wdt_clear = wr && ((idx == REG_WDT_KICK) || (idx == REG_WDT_LIMIT));

  sim_exit_ctrl_wdt u_wdt (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .limit_i  (wdt_limit_q),
    .clear_i  (wdt_clear),
    .freeze_i (exited),
    .expire_o (wdt_expire)
  );

  // State machine and register updates.
  always_comb begin
    state_d       = state_q;
    exit_value_d  = exit_value_q;
    wdt_limit_d   = wdt_limit_q;
    wdt_expired_d = wdt_expired_q;

    if (running && wr) begin
      if (idx == REG_EXIT_VALUE) exit_value_d = apply_be(exit_value_q, wdata_i, be_i);
      if (idx == REG_WDT_LIMIT)  wdt_limit_d  = apply_be(wdt_limit_q, wdata_i, be_i);
    end

    // Software exit takes priority over a coincident watchdog expiry.
    if (sw_exit) begin
      state_d = EXITED;
    end else if (running && wdt_expire) begin
      state_d       = EXITED;
      exit_value_d  = WDT_EXIT_CODE;
      wdt_expired_d = 1'b1;
    end
  end

  // Read decode; a CYCLE_LO read also captures the high word so a following
  // CYCLE_HI read is coherent with it.
  always_comb begin
    rdata_d  = 32'd0;
    shadow_d = shadow_q;
    if (rd) begin
      case (idx)
        REG_EXIT_VALUE: rdata_d = exit_value_q;
        REG_EXIT_VALID: rdata_d = {31'b0, exited};
        REG_CYCLE_LO: begin
          rdata_d  = cycle_q[31:0];
          shadow_d = cycle_q[63:32];
        end
        REG_CYCLE_HI:   rdata_d = shadow_q;
        REG_WDT_LIMIT:  rdata_d = wdt_limit_q;
        REG_STATUS:     rdata_d = {30'b0, wdt_expired_q, exited};
        default:        rdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= RUN;
      exit_value_q  <= 32'd0;
      wdt_limit_q   <= WDT_RESET_LIMIT;
      wdt_expired_q <= 1'b0;
      cycle_q       <= 64'd0;
      shadow_q      <= 32'd0;
      rvalid_q      <= 1'b0;
      rdata_q       <= 32'd0;
    end else begin
      state_q       <= state_d;
      exit_value_q  <= exit_value_d;
      wdt_limit_q   <= wdt_limit_d;
      wdt_expired_q <= wdt_expired_d;
      cycle_q       <= cycle_q + 64'd1;
      shadow_q      <= shadow_d;
      rvalid_q      <= req_i;
      rdata_q       <= rdata_d;
    end
  end

  assign gnt_o        = req_i;
  assign rvalid_o     = rvalid_q;
  assign rdata_o      = rdata_q;
  assign exit_valid_o = exited;
  assign exit_value_o = exit_value_q;

endmodule

// File: tb/tb_sim_exit_ctrl.sv
module tb_sim_exit_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  be = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        exit_valid;
  logic [31:0] exit_value;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Scoreboard: one entry per request, popped on the response cycle.
  logic [31:0] exp_q[$];
  bit          chk_q[$];
  int          stamp_q[$];

  sim_exit_ctrl dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_i        (req),
    .we_i         (we),
    .be_i         (be),
    .addr_i       (addr),
    .wdata_i      (wdata),
    .gnt_o        (gnt),
    .rvalid_o     (rvalid),
    .rdata_o      (rdata),
    .exit_valid_o (exit_valid),
    .exit_value_o (exit_value)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic flush_sb();
    exp_q.delete();
    chk_q.delete();
    stamp_q.delete();
  endtask

  // Called at a falling edge; returns at a falling edge with reset released.
  task automatic do_reset();
    rst_n = 1'b0;
    req   = 1'b0;
    we    = 1'b0;
    flush_sb();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge; grant happens on the next rising edge and the
  // task returns on the falling edge after it, so calls chain back-to-back.
  task automatic bus_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] b, input logic [31:0] exp);
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    exp_q.push_back(exp);
    chk_q.push_back(!w);
    stamp_q.push_back(cyc);
    @(posedge clk);
    @(negedge clk);
    req = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus_txn(1'b1, a, d, 4'hF, 32'h0);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp);
    bus_txn(1'b0, a, 32'h0, 4'hF, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (stamp_q.size() > 0 && stamp_q[0] + 1 == cyc) begin
        total++;
        if (rvalid !== 1'b1) begin
          bad++;
          $display("FAIL rvalid_missing: got rvalid=%b want 1 (cycle %0d)", rvalid, cyc);
        end else if (chk_q[0] && rdata !== exp_q[0]) begin
          bad++;
          $display("FAIL rdata: got %h want %h (cycle %0d)", rdata, exp_q[0], cyc);
        end
        void'(exp_q.pop_front());
        void'(chk_q.pop_front());
        void'(stamp_q.pop_front());
      end else if (rvalid !== 1'b0) begin
        total++;
        bad++;
        $display("FAIL rvalid_unexpected: got rvalid=%b want 0 (cycle %0d)", rvalid, cyc);
      end
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    req = 1'b1; #1;
    total++; if (gnt !== 1'b1) begin bad++; $display("FAIL reset_gnt_hi: got %b want 1", gnt); end
    req = 1'b0; #1;
    total++; if (gnt !== 1'b0) begin bad++; $display("FAIL reset_gnt_lo: got %b want 0", gnt); end
    total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid: got %b want 0", rvalid); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    total++; if (exit_valid !== 1'b0) begin bad++; $display("FAIL reset_exit_valid: got %b want 0", exit_valid); end
    total++; if (exit_value !== 32'h0) begin bad++; $display("FAIL reset_exit_value: got %h want 0", exit_value); end
    @(negedge clk);
    rst_n = 1'b1;
    rd(32'h10, 32'h0);
    rd(32'h18, 32'h0);
    rd(32'h0C, 32'h0);
    rd(32'h00, 32'h0);
    idle(1);
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL idle_rdata: got %h want 0", rdata); end
  endtask

  task automatic test_sw_exit_zero();
    do_reset();
    wr(32'h00, 32'h0);
    total++; if (exit_valid !== 1'b0) begin bad++; $display("FAIL pre_exit_valid: got %b want 0", exit_valid); end
    wr(32'h04, 32'h1);
    total++; if (exit_valid !== 1'b1) begin bad++; $display("FAIL sw_exit_valid: got %b want 1", exit_valid); end
    total++; if (exit_value !== 32'h0) begin bad++; $display("FAIL sw_exit_value: got %h want 0", exit_value); end
    rd(32'h04, 32'h1);
  endtask

  task automatic test_sw_exit_locked();
    do_reset();
    wr(32'h00, 32'h2A);
    wr(32'h04, 32'h1);
    wr(32'h00, 32'h55);
    total++; if (exit_value !== 32'h2A) begin bad++; $display("FAIL locked_exit_value: got %h want 2a", exit_value); end
    rd(32'h18, 32'h1);
    rd(32'h00, 32'h2A);
    wr(32'h10, 32'h5);
    rd(32'h10, 32'h0);
    idle(3);
    total++; if (exit_valid !== 1'b1) begin bad++; $display("FAIL sticky_exit_valid: got %b want 1", exit_valid); end
  endtask

  task automatic test_byte_enable();
    do_reset();
    wr(32'h00, 32'hFFFF_FFFF);
    bus_txn(1'b1, 32'h00, 32'h1234_5678, 4'b0101, 32'h0);
    rd(32'h00, 32'hFF34_FF78);
    bus_txn(1'b1, 32'h04, 32'h1, 4'b1110, 32'h0);
    wr(32'h04, 32'h0);
    total++; if (exit_valid !== 1'b0) begin bad++; $display("FAIL no_exit_be: got %b want 0", exit_valid); end
    wr(32'h1C, 32'hFFFF_FFFF);
    rd(32'h1C, 32'h0);
    rd(32'h14, 32'h0);
    bus_txn(1'b1, 32'h10, 32'hAABB_CCDD, 4'b0010, 32'h0);
    rd(32'h10, 32'h0000_CC00);
  endtask

  task automatic test_wdt_expire();
    do_reset();
    wr(32'h10, 32'd10);
    idle(9);
    total++; if (exit_valid !== 1'b0) begin bad++; $display("FAIL wdt_early: got %b want 0", exit_valid); end
    idle(1);
    total++; if (exit_valid !== 1'b1) begin bad++; $display("FAIL wdt_exit_valid: got %b want 1", exit_valid); end
    total++; if (exit_value !== 32'hDEAD_0001) begin bad++; $display("FAIL wdt_exit_value: got %h want dead0001", exit_value); end
    rd(32'h18, 32'h3);
    rd(32'h00, 32'hDEAD_0001);
    rd(32'h10, 32'd10);
  endtask

  task automatic test_wdt_kick();
    do_reset();
    wr(32'h10, 32'd4);
    for (int i = 0; i < 34; i++) begin
      idle(2);
      wr(32'h14, 32'h0);
    end
    total++; if (exit_valid !== 1'b0) begin bad++; $display("FAIL kick_periodic: got %b want 0", exit_valid); end
    // Kick granted in the cycle where the count sits at limit-1.
    idle(3);
    wr(32'h14, 32'h0);
    total++; if (exit_valid !== 1'b0) begin bad++; $display("FAIL kick_exact: got %b want 0", exit_valid); end
    idle(3);
    total++; if (exit_valid !== 1'b0) begin bad++; $display("FAIL kick_after_early: got %b want 0", exit_valid); end
    idle(1);
    total++; if (exit_valid !== 1'b1) begin bad++; $display("FAIL kick_stop_expire: got %b want 1", exit_valid); end
    total++; if (exit_value !== 32'hDEAD_0001) begin bad++; $display("FAIL kick_stop_value: got %h want dead0001", exit_value); end
  endtask

  task automatic test_sw_vs_wdt();
    do_reset();
    wr(32'h00, 32'h77);
    wr(32'h10, 32'd3);
    idle(1);
    wr(32'h04, 32'h1);
    total++; if (exit_valid !== 1'b1) begin bad++; $display("FAIL race_exit_valid: got %b want 1", exit_valid); end
    total++; if (exit_value !== 32'h77) begin bad++; $display("FAIL race_exit_value: got %h want 77", exit_value); end
    rd(32'h18, 32'h1);
  endtask

  task automatic test_cycle_wrap();
    do_reset();
    force dut.cycle_q = 64'h0000_0000_FFFF_FFFE;
    #1;
    release dut.cycle_q;
    @(negedge clk);
    rd(32'h08, 32'hFFFF_FFFF);
    rd(32'h0C, 32'h0000_0000);
    rd(32'h08, 32'h0000_0001);
    rd(32'h0C, 32'h0000_0001);
    force dut.cycle_q = 64'h0000_0001_0000_0004;
    #1;
    release dut.cycle_q;
    @(negedge clk);
    rd(32'h08, 32'h0000_0005);
    rd(32'h0C, 32'h0000_0001);
  endtask

  task automatic test_reset_mid();
    do_reset();
    wr(32'h04, 32'h1);
    total++; if (exit_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_exit: got %b want 1", exit_valid); end
    req = 1'b1; we = 1'b0; addr = 32'h0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    req = 1'b0;
    #1;
    total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL mid_rvalid: got %b want 0", rvalid); end
    total++; if (exit_valid !== 1'b0) begin bad++; $display("FAIL mid_exit_valid: got %b want 0", exit_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    rd(32'h08, 32'h0);
    rd(32'h18, 32'h0);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_sw_exit_zero();
    test_sw_exit_locked();
    test_byte_enable();
    test_wdt_expire();
    test_wdt_kick();
    test_sw_vs_wdt();
    test_cycle_wrap();
    test_reset_mid();
    idle(2);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
